spi_cmd_decoder: RTL and testbench

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

---
 rtl/spi_cmd_pkg.sv | 38 +++
 rtl/spi_xor_csum.sv | 16 +
 rtl/spi_cmd_decoder.sv | 160 ++++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: frame layout, opcodes,
// status codes and FSM state encodings.
package spi_cmd_pkg;

  localparam int FRAME_W    = 136;
  localparam int CSUM_W     = 8;
  localparam int CSUM_BYTES = (FRAME_W - CSUM_W) / 8;

  localparam int OP_HI   = 135;
  localparam int OP_LO   = 128;
  localparam int ADDR_HI = 127;
  localparam int ADDR_LO = 120;
  localparam int DATA_HI = 119;
  localparam int DATA_LO = 88;
  localparam int SEQ_HI  = 87;
  localparam int SEQ_LO  = 80;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_BAD_CSUM = 8'hE1;
  localparam logic [7:0] ST_BAD_OP   = 8'hE2;
  localparam logic [7:0] ST_BAD_ADDR = 8'hE3;
  localparam logic [7:0] ST_RO_WRITE = 8'hE4;

  localparam logic [7:0] STAT_BASE = 8'h10;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LATCH    = 3'd1,
    S_CHECK    = 3'd2,
    S_EXEC     = 3'd3,
    S_WAIT_END = 3'd4
  } state_t;

endpackage

// File: rtl/spi_xor_csum.sv
// Combinational XOR of the 16 payload bytes above the checksum byte.
module spi_xor_csum
  import spi_cmd_pkg::*;
(
  input  logic [FRAME_W-1:CSUM_W] body,
  output logic [CSUM_W-1:0]       csum
);

  always_comb begin
    csum = '0;
    for (int i = 0; i < CSUM_BYTES; i++) begin
      csum = csum ^ body[CSUM_W + 8*i +: 8];
    end
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Decodes 136-bit SPI request frames into config writes / register reads and
// stages a checksummed response that is presented once the frame has ended.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int NSTAT = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [FRAME_W-1:0]    RECEIVED,
  input  logic                  RXED,
  input  logic [32*NSTAT-1:0]   STATUS_IN,
  output logic [FRAME_W-1:0]    TO_SEND,
  output logic [32*NREG-1:0]    CFG,
  output logic                  CMD_DONE,
  output logic [7:0]            ERR_CNT
);

  state_t state_reg, state_next;
  logic rxed_reg, rxed_rise;
  logic latch_en, check_en, exec_en, load_en;
  logic [FRAME_W-1:0] frame_reg, staging_reg, to_send_reg;
  logic [7:0] status_reg, status_next, seq_reg, err_cnt_reg;
  logic cmd_done_reg;
  logic [7:0] op, addr;
  logic [31:0] wdata, cfg_rd, stat_rd, rdata;
  logic is_cfg, is_stat, op_ok;
  logic [FRAME_W-1:CSUM_W] csum_body, resp_body;
  logic [CSUM_W-1:0] csum;

  // Reset to 1 so a frame still in flight when reset drops is not re-seen as new.
  always_ff @(posedge CLK) begin
    if (RESET) rxed_reg <= 1'b1;
    else       rxed_reg <= RXED;
  end
  assign rxed_rise = RXED & ~rxed_reg;

  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (rxed_rise) state_next = S_LATCH;
      S_LATCH:    state_next = S_CHECK;
      S_CHECK:    state_next = S_EXEC;
      S_EXEC:     state_next = S_WAIT_END;
      S_WAIT_END: if (!rxed_reg) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_comb begin
    latch_en = 1'b0;
    check_en = 1'b0;
    exec_en  = 1'b0;
    load_en  = 1'b0;
    case (state_reg)
      S_LATCH:    latch_en = 1'b1;
      S_CHECK:    check_en = 1'b1;
      S_EXEC:     exec_en  = 1'b1;
      S_WAIT_END: load_en  = ~rxed_reg;
      default:    ;
    endcase
  end

  assign op    = frame_reg[OP_HI:OP_LO];
  assign addr  = frame_reg[ADDR_HI:ADDR_LO];
  assign wdata = frame_reg[DATA_HI:DATA_LO];
  assign op_ok = (op == OP_NOP) || (op == OP_WRITE) || (op == OP_READ);

  always_comb begin
    is_cfg = 1'b0;
    cfg_rd = '0;
    for (int k = 0; k < NREG; k++) begin
      if (addr == 8'(k)) begin
        is_cfg = 1'b1;
        cfg_rd = CFG[32*k +: 32];
      end
    end
    is_stat = 1'b0;
    stat_rd = '0;
    for (int k = 0; k < NSTAT; k++) begin
      if (addr == STAT_BASE + 8'(k)) begin
        is_stat = 1'b1;
        stat_rd = STATUS_IN[32*k +: 32];
      end
    end
  end

  // NOP carries no address, so only READ/WRITE are range-checked.
  always_comb begin
    if (csum != frame_reg[CSUM_W-1:0])                     status_next = ST_BAD_CSUM;
    else if (!op_ok)                                      status_next = ST_BAD_OP;
    else if (op != OP_NOP && !is_cfg && !is_stat)         status_next = ST_BAD_ADDR;
    else if (op == OP_WRITE && is_stat)                   status_next = ST_RO_WRITE;
    else                                                  status_next = ST_OK;
  end

  always_comb begin
    rdata = '0;
    if (status_reg == ST_OK) begin
      if (op == OP_WRITE)     rdata = wdata;
      else if (op == OP_READ) rdata = is_cfg ? cfg_rd : stat_rd;
    end
  end

  assign resp_body = {status_reg, addr, rdata, seq_reg, {(SEQ_LO-CSUM_W){1'b0}}};
  // One checksum unit: request body while checking, response body while executing.
  assign csum_body = exec_en ? resp_body : frame_reg[FRAME_W-1:CSUM_W];

  spi_xor_csum u_csum (
    .body (csum_body),
    .csum (csum)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_reg    <= '0;
      status_reg   <= '0;
      staging_reg  <= '0;
      to_send_reg  <= '0;
      cmd_done_reg <= 1'b0;
      seq_reg      <= '0;
      err_cnt_reg  <= '0;
    end else begin
      cmd_done_reg <= load_en;
      if (latch_en) frame_reg  <= RECEIVED;
      if (check_en) status_reg <= status_next;
      if (exec_en) begin
        staging_reg <= {resp_body, csum};
        if (status_reg != ST_OK && err_cnt_reg != 8'hFF)
          err_cnt_reg <= err_cnt_reg + 8'd1;
      end
      if (load_en) begin
        to_send_reg <= staging_reg;
        seq_reg     <= seq_reg + 8'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_cfg
    logic [31:0] word_reg;
    always_ff @(posedge CLK) begin
      if (RESET)
        word_reg <= '0;
      else if (exec_en && status_reg == ST_OK && op == OP_WRITE && addr == 8'(gi))
        word_reg <= wdata;
    end
    assign CFG[32*gi +: 32] = word_reg;
  end

  assign TO_SEND  = to_send_reg;
  assign CMD_DONE = cmd_done_reg;
  assign ERR_CNT  = err_cnt_reg;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed table-driven bench for spi_cmd_decoder plus reset/saturation sequences.
module tb_spi_cmd_decoder;

  logic CLK = 1'b0;
  logic RESET;
  logic [135:0] RECEIVED;
  logic RXED;
  logic [127:0] STATUS_IN;
  logic [135:0] TO_SEND;
  logic [255:0] CFG;
  logic CMD_DONE;
  logic [7:0] ERR_CNT;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  spi_cmd_decoder #(.NREG(8), .NSTAT(4)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .RECEIVED  (RECEIVED),
    .RXED      (RXED),
    .STATUS_IN (STATUS_IN),
    .TO_SEND   (TO_SEND),
    .CFG       (CFG),
    .CMD_DONE  (CMD_DONE),
    .ERR_CNT   (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (CMD_DONE) done_cnt++;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          bad_csum;
    int          hold;
    logic [7:0]  exp_status;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [7:0] xsum(input logic [135:0] f);
    logic [7:0] s = 8'h00;
    for (int b = 1; b < 17; b++) s ^= f[8*b +: 8];
    return s;
  endfunction

  function automatic logic [135:0] mk_req(input logic [7:0] op, input logic [7:0] addr,
                                          input logic [31:0] data, input bit bad);
    logic [135:0] f;
    f = {op, addr, data, 80'h0123_4567_89AB_CDEF_0011, 8'h00};
    f[7:0] = xsum(f) ^ (bad ? 8'hFF : 8'h00);
    return f;
  endfunction

  function automatic logic [135:0] mk_resp(input logic [7:0] st, input logic [7:0] addr,
                                           input logic [31:0] data, input logic [7:0] seq);
    logic [135:0] f;
    f = {st, addr, data, seq, 72'h0, 8'h00};
    f[7:0] = xsum(f);
    return f;
  endfunction

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [135:0] f, input int hold, input bit chk_stable,
                           input logic [135:0] prev, output int lat);
    RECEIVED = f;
    RXED = 1'b1;
    for (int c = 0; c < hold; c++) begin
      @(posedge CLK); #1;
      if (c == 2) RECEIVED = ~f;
    end
    if (chk_stable) chk("to_send_stable", TO_SEND, prev);
    RXED = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(posedge CLK); #1;
      if (CMD_DONE) lat = k;
    end
    RECEIVED = ~f;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  logic [31:0] cfg_m [8];
  logic [135:0] prev_resp, exp_resp;
  logic [7:0] seq;
  int exp_err;
  int lat, d0;

  initial begin
    vecs[0]  = '{8'h01, 8'h03, 32'hDEADBEEF, 1'b0, 20, 8'h00, 32'hDEADBEEF, 2};
    vecs[1]  = '{8'h02, 8'h11, 32'h0,        1'b0, 20, 8'h00, 32'h12345678, 2};
    vecs[2]  = '{8'h02, 8'h03, 32'h0,        1'b0, 20, 8'h00, 32'hDEADBEEF, 2};
    vecs[3]  = '{8'h01, 8'h05, 32'hCAFEF00D, 1'b1,  1, 8'hE1, 32'h0,        4};
    vecs[4]  = '{8'h02, 8'h05, 32'h0,        1'b0, 20, 8'h00, 32'h0,        2};
    vecs[5]  = '{8'h07, 8'h00, 32'h0,        1'b0, 20, 8'hE2, 32'h0,        2};
    vecs[6]  = '{8'h02, 8'h09, 32'h0,        1'b0,  2, 8'hE3, 32'h0,        3};
    vecs[7]  = '{8'h01, 8'h10, 32'h00000001, 1'b0, 20, 8'hE4, 32'h0,        2};
    vecs[8]  = '{8'h00, 8'h02, 32'h55555555, 1'b0,  1, 8'h00, 32'h0,        4};
    vecs[9]  = '{8'h01, 8'h07, 32'hA5A5A5A5, 1'b0, 20, 8'h00, 32'hA5A5A5A5, 2};
    vecs[10] = '{8'h02, 8'h13, 32'h0,        1'b0, 20, 8'h00, 32'hFFFF0003, 2};
    vecs[11] = '{8'h02, 8'h14, 32'h0,        1'b0, 20, 8'hE3, 32'h0,        2};
    vecs[12] = '{8'h02, 8'h08, 32'h0,        1'b0, 20, 8'hE3, 32'h0,        2};

    STATUS_IN = {32'hFFFF0003, 32'h0BADF00D, 32'h12345678, 32'hA0A0A0A0};
    RESET = 1'b1;
    RXED = 1'b0;
    RECEIVED = '0;
    for (int i = 0; i < 8; i++) cfg_m[i] = '0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("reset_to_send", TO_SEND, '0);
    chk("reset_cfg", {8'h0, CFG[127:0]}, '0);
    chk("reset_cfg_hi", {8'h0, CFG[255:128]}, '0);
    chk("reset_cmd_done", {135'h0, CMD_DONE}, '0);
    chk("reset_err_cnt", {128'h0, ERR_CNT}, '0);

    prev_resp = '0;
    seq = 8'h00;
    exp_err = 0;
    for (int i = 0; i < 13; i++) begin
      exp_resp = mk_resp(vecs[i].exp_status, vecs[i].addr, vecs[i].exp_data, seq);
      d0 = done_cnt;
      run_frame(mk_req(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].bad_csum),
                vecs[i].hold, 1'b1, prev_resp, lat);
      if (vecs[i].exp_status != 8'h00) exp_err++;
      if (vecs[i].exp_status == 8'h00 && vecs[i].op == 8'h01) cfg_m[vecs[i].addr[2:0]] = vecs[i].data;
      $display("vec %0d op=%0h addr=%0h lat=%0d to_send=%0h err_cnt=%0d",
               i, vecs[i].op, vecs[i].addr, lat, TO_SEND, ERR_CNT);
      chk($sformatf("latency_%0d", i), lat, vecs[i].exp_lat);
      chk($sformatf("to_send_%0d", i), TO_SEND, exp_resp);
      chk($sformatf("err_cnt_%0d", i), {128'h0, ERR_CNT}, exp_err);
      chk($sformatf("done_pulses_%0d", i), done_cnt - d0, 1);
      if (vecs[i].addr < 8'd8)
        chk($sformatf("cfg_word_%0d", i), {104'h0, CFG[32*vecs[i].addr +: 32]},
            {104'h0, cfg_m[vecs[i].addr[2:0]]});
      prev_resp = exp_resp;
      seq++;
    end

    for (int n = 0; n < 300; n++) begin
      run_frame(mk_req(8'h07, 8'h00, 32'h0, 1'b0), 1, 1'b0, prev_resp, lat);
    end
    $display("saturation err_cnt=%0d to_send=%0h", ERR_CNT, TO_SEND);
    chk("err_cnt_saturated", {128'h0, ERR_CNT}, 255);
    chk("to_send_after_300", TO_SEND, mk_resp(8'hE2, 8'h00, 32'h0, seq + 8'd43));
    chk("cfg_after_300", {104'h0, CFG[32*3 +: 32]}, 32'hDEADBEEF);

    d0 = done_cnt;
    RECEIVED = mk_req(8'h01, 8'h00, 32'h11112222, 1'b0);
    RXED = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    RXED = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    $display("reset_abort cfg0=%0h to_send=%0h done=%0d", CFG[31:0], TO_SEND, done_cnt - d0);
    chk("abort_cfg0", {104'h0, CFG[31:0]}, '0);
    chk("abort_to_send", TO_SEND, '0);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_err_cnt", {128'h0, ERR_CNT}, '0);

    d0 = done_cnt;
    run_frame(mk_req(8'h02, 8'h11, 32'h0, 1'b0), 20, 1'b1, '0, lat);
    $display("post_reset read lat=%0d to_send=%0h", lat, TO_SEND);
    chk("post_reset_lat", lat, 2);
    chk("post_reset_to_send", TO_SEND, mk_resp(8'h00, 8'h11, 32'h12345678, 8'h00));
    chk("post_reset_done", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
